// File: rtl/a5_1_pkg.sv
// a5_1_pkg: constants shared by the A5/1 sequencer and its helpers.
//   - phase lengths for key and frame load
//   - X/Y/Z register lengths and majority-tap indices
//   - FSM state encoding (plain constants so older tools can use them too)
//   - maj3(): 2-of-3 majority vote
package a5_1_pkg;

   localparam int KEY_LEN   = 64;
   localparam int FRAME_LEN = 22;

   localparam int X_LEN = 19;
   localparam int Y_LEN = 22;
   localparam int Z_LEN = 23;

   localparam int X_MAJ_IDX = 8;
   localparam int Y_MAJ_IDX = 10;
   localparam int Z_MAJ_IDX = 10;

   localparam int PHASE_W = 7;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE       = 3'd0;
   localparam state_t ST_CLEAR      = 3'd1;
   localparam state_t ST_LOAD_KEY   = 3'd2;
   localparam state_t ST_LOAD_FRAME = 3'd3;
   localparam state_t ST_MIX        = 3'd4;
   localparam state_t ST_RUN        = 3'd5;
   localparam state_t ST_DONE       = 3'd6;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/a5_1_sequencer_if.sv
// a5_1_sequencer_if: keystream valid/ready link from the sequencer to the
// image-XOR stage.
//   ks_bit        keystream bit (sequencer -> consumer)
//   ks_valid      ks_bit is valid (sequencer -> consumer)
//   ks_ready      consumer takes ks_bit this cycle (consumer -> sequencer)
//   ks_byte       packed keystream byte, LSB first  (only with A51_BYTE_OUT_EN)
//   ks_byte_valid one-cycle strobe for ks_byte        (only with A51_BYTE_OUT_EN)
interface a5_1_sequencer_if;

   logic ks_bit;
   logic ks_valid;
   logic ks_ready;

`ifdef A51_BYTE_OUT_EN
   logic [7:0] ks_byte;
   logic       ks_byte_valid;

   modport master (output ks_bit, output ks_valid, input ks_ready,
                   output ks_byte, output ks_byte_valid);
   modport slave  (input ks_bit, input ks_valid, output ks_ready,
                   input ks_byte, input ks_byte_valid);
`else
   modport master (output ks_bit, output ks_valid, input ks_ready);
   modport slave  (input ks_bit, input ks_valid, output ks_ready);
`endif

endinterface

// File: rtl/a5_1_majority_clk.sv
// a5_1_majority_clk: A5/1 majority clock selection.
//   en                 allow any register to step this cycle
//   x_maj/y_maj/z_maj  clocking taps of the X/Y/Z registers
//   trig_x/y/z         step enable per register: a register steps when its
//                      tap agrees with the majority, so at least two step
module a5_1_majority_clk
   import a5_1_pkg::*;
(
   input  logic en,
   input  logic x_maj,
   input  logic y_maj,
   input  logic z_maj,
   output logic trig_x,
   output logic trig_y,
   output logic trig_z
);

   logic m;

   assign m      = maj3(x_maj, y_maj, z_maj);
   assign trig_x = en & (x_maj == m);
   assign trig_y = en & (y_maj == m);
   assign trig_z = en & (z_maj == m);

endmodule

// File: rtl/a5_1_sequencer.sv
// a5_1_sequencer: control end of the A5/1 X/Y/Z register set.
// Sequences clear, key load, frame load, majority mixing and keystream
// generation, and hands keystream bits to the consumer over a valid/ready link.
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   session request, sampled only in IDLE
//   key[63:0], frame[21:0]  session inputs, bit 0 shifted in first
//   x/y/z_maj, x/y/z_out    register read-back (clocking tap, MSB output)
//   reg_clear, shift_bit    register clear pulse and injected feedback bit
//   trig_x/y/z              per-register step enables (combinational)
//   busy, done              session status
//   ks                      keystream link (a5_1_sequencer_if.master)
// Build option: A51_BYTE_OUT_EN adds an LSB-first byte packer on ks.
//
// state          | meaning
// ST_IDLE        | waiting for start
// ST_CLEAR       | one-cycle register clear
// ST_LOAD_KEY    | 64 cycles, all registers step, key bits injected
// ST_LOAD_FRAME  | 22 cycles, all registers step, frame bits injected
// ST_MIX         | MIX_CYCLES majority-clocked steps, output discarded
// ST_RUN         | keystream delivery, stepping only on a transfer
// ST_DONE        | one-cycle done pulse
module a5_1_sequencer
   import a5_1_pkg::*;
#(
   parameter int KS_LEN     = 228,
   parameter int MIX_CYCLES = 100
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [KEY_LEN-1:0]     key,
   input  logic [FRAME_LEN-1:0]   frame,
   input  logic                   x_maj,
   input  logic                   y_maj,
   input  logic                   z_maj,
   input  logic                   x_out,
   input  logic                   y_out,
   input  logic                   z_out,
   output logic                   reg_clear,
   output logic                   shift_bit,
   output logic                   trig_x,
   output logic                   trig_y,
   output logic                   trig_z,
   output logic                   busy,
   output logic                   done,
   a5_1_sequencer_if.master       ks
);

   localparam int BIT_W = $clog2(KS_LEN + 1);
   localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(KS_LEN - 1);
   localparam logic [PHASE_W-1:0] KEY_LAST   = PHASE_W'(KEY_LEN - 1);
   localparam logic [PHASE_W-1:0] FRAME_LAST = PHASE_W'(FRAME_LEN - 1);
   localparam logic [PHASE_W-1:0] MIX_LAST   = PHASE_W'(MIX_CYCLES - 1);

   state_t                 state_q, state_d;
   logic [PHASE_W-1:0]     phase_q, phase_d;
   logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [KEY_LEN-1:0]     key_q, key_d;
   logic [FRAME_LEN-1:0]   frame_q, frame_d;
   logic                   reg_clear_q, reg_clear_d;
   logic                   shift_bit_q, shift_bit_d;
   logic                   ks_valid_q, ks_valid_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic xfer;
   logic loading;
   logic maj_en;
   logic maj_x, maj_y, maj_z;

   assign xfer    = (state_q == ST_RUN) & ks_valid_q & ks.ks_ready;
   assign loading = (state_q == ST_LOAD_KEY) | (state_q == ST_LOAD_FRAME);
   assign maj_en  = (state_q == ST_MIX) | xfer;

   a5_1_majority_clk u_majority_clk (
      .en     (maj_en),
      .x_maj  (x_maj),
      .y_maj  (y_maj),
      .z_maj  (z_maj),
      .trig_x (maj_x),
      .trig_y (maj_y),
      .trig_z (maj_z)
   );

   assign trig_x = loading | maj_x;
   assign trig_y = loading | maj_y;
   assign trig_z = loading | maj_z;

   // Registers do not step while the consumer stalls, so ks_bit stays put.
   assign ks.ks_bit   = x_out ^ y_out ^ z_out;
   assign ks.ks_valid = ks_valid_q;
   assign reg_clear   = reg_clear_q;
   assign shift_bit   = shift_bit_q;
   assign busy        = busy_q;
   assign done        = done_q;

   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      frame_d   = frame_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CLEAR;
               key_d   = key;
               frame_d = frame;
            end
         end
         ST_CLEAR: begin
            state_d   = ST_LOAD_KEY;
            bit_cnt_d = '0;
         end
         ST_LOAD_KEY:   if (phase_q == KEY_LAST)   state_d = ST_LOAD_FRAME;
         ST_LOAD_FRAME: if (phase_q == FRAME_LAST) state_d = ST_MIX;
         ST_MIX:        if (phase_q == MIX_LAST)   state_d = ST_RUN;
         ST_RUN: begin
            if (xfer) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BIT_LAST) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      phase_d = '0;
      if (state_d == state_q && (loading || state_q == ST_MIX)) begin
         phase_d = (phase_q == '1) ? phase_q : phase_q + 1'b1;
      end

      // Registered outputs are computed from the next state so they line
      // up with the state they belong to.
      reg_clear_d = (state_d == ST_CLEAR);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      ks_valid_d  = (state_d == ST_RUN);
      shift_bit_d = 1'b0;
      if (state_d == ST_LOAD_KEY)   shift_bit_d = key_q[phase_d[5:0]];
      if (state_d == ST_LOAD_FRAME) shift_bit_d = frame_q[phase_d[4:0]];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         phase_q     <= '0;
         bit_cnt_q   <= '0;
         key_q       <= '0;
         frame_q     <= '0;
         reg_clear_q <= 1'b0;
         shift_bit_q <= 1'b0;
         ks_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         bit_cnt_q   <= bit_cnt_d;
         key_q       <= key_d;
         frame_q     <= frame_d;
         reg_clear_q <= reg_clear_d;
         shift_bit_q <= shift_bit_d;
         ks_valid_q  <= ks_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef A51_BYTE_OUT_EN
   logic [7:0] pack_q, pack_d;
   logic [2:0] pos_q, pos_d;
   logic [7:0] byte_q, byte_d;
   logic       byte_valid_q, byte_valid_d;
   logic [7:0] pack_next;

   assign pack_next = pack_q | (8'(ks.ks_bit) << pos_q);

   // The last bit of a session flushes whatever is packed; unfilled upper
   // bits are already zero because the packer restarts from zero.
   always_comb begin
      pack_d       = pack_q;
      pos_d        = pos_q;
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      if (state_q == ST_CLEAR) begin
         pack_d = '0;
         pos_d  = '0;
      end else if (xfer) begin
         if (pos_q == 3'd7 || bit_cnt_q == BIT_LAST) begin
            byte_d       = pack_next;
            byte_valid_d = 1'b1;
            pack_d       = '0;
            pos_d        = '0;
         end else begin
            pack_d = pack_next;
            pos_d  = pos_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pack_q       <= '0;
         pos_q        <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
      end else begin
         pack_q       <= pack_d;
         pos_q        <= pos_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
      end
   end

   assign ks.ks_byte       = byte_q;
   assign ks.ks_byte_valid = byte_valid_q;
`endif

endmodule
